// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver and scan-code decoder that tracks the up/down state of
// a configurable set of keys. It reports press, release and typematic events.
module ps2_key_tracker #(
  parameter int                    NUM_KEYS       = 3,
  parameter logic [8*NUM_KEYS-1:0] KEY_CODES      = {8'h29, 8'h23, 8'h1C},
  parameter logic [NUM_KEYS-1:0]   KEY_EXT        = {NUM_KEYS{1'b0}},
  parameter int                    TIMEOUT_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  input  logic                clear_keys,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                scan_valid,
  output logic [7:0]          scan_code,
  output logic                scan_ext,
  output logic                scan_brk,
  output logic                parity_err,
  output logic                frame_err
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0] TO_ZERO = TO_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  logic            clk_meta_r, clk_sync_r, clk_prev_r;
  logic            data_meta_r, data_sync_r;
  logic            fall_s;
  logic [3:0]      bit_cnt_r;
  logic [8:0]      shift_r;
  logic [TO_W-1:0] to_cnt_r;
  logic            byte_valid_r;
  logic [7:0]      byte_r;
  logic            parity_err_r, frame_err_r;

  dec_state_t      state_r, state_nxt_s;
  logic            evt_s, evt_ext_s, evt_brk_s;

  logic [NUM_KEYS-1:0] upd_held_s, upd_press_s, upd_release_s, upd_repeat_s;
  logic [NUM_KEYS-1:0] held_nxt_s, press_nxt_s, release_nxt_s, repeat_nxt_s;
  logic [NUM_KEYS-1:0] key_held_r, key_press_r, key_release_r, key_repeat_r;
  logic                scan_valid_r, scan_ext_r, scan_brk_r;
  logic [7:0]          scan_code_r;

  // Two-flop synchronisers on both PS/2 lines, plus the previous clock level for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  // A PS/2 bit is valid on the falling edge of the synchronised clock.
  always_comb begin
    fall_s = clk_prev_r & ~clk_sync_r;
  end

  // Frame receiver: start bit, 9 shifted bits (data LSB first + parity), then the stop check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_r    <= 4'd0;
      shift_r      <= 9'd0;
      to_cnt_r     <= TO_ZERO;
      byte_valid_r <= 1'b0;
      byte_r       <= 8'd0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      if (fall_s) begin
        to_cnt_r <= TO_ZERO;
        if (bit_cnt_r == 4'd0) begin
          if (!data_sync_r) begin
            bit_cnt_r <= 4'd1;
          end
        end else if (bit_cnt_r < 4'd10) begin
          shift_r   <= {data_sync_r, shift_r[8:1]};
          bit_cnt_r <= bit_cnt_r + 4'd1;
        end else begin
          bit_cnt_r <= 4'd0;
          // A bad stop bit dominates a bad parity bit.
          if (!data_sync_r) begin
            frame_err_r <= 1'b1;
          end else if (!(^shift_r)) begin
            parity_err_r <= 1'b1;
          end else begin
            byte_valid_r <= 1'b1;
            byte_r       <= shift_r[7:0];
          end
        end
      end else if (bit_cnt_r != 4'd0) begin
        if (to_cnt_r == TO_LAST) begin
          bit_cnt_r   <= 4'd0;
          to_cnt_r    <= TO_ZERO;
          frame_err_r <= 1'b1;
        end else begin
          to_cnt_r <= to_cnt_r + TO_ONE;
        end
      end else begin
        to_cnt_r <= TO_ZERO;
      end
    end
  end

  // Decoder state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Decoder next state: E0/F0 prefixes accumulate, and any other byte finalises an event.
  always_comb begin
    state_nxt_s = state_r;
    evt_s       = 1'b0;
    evt_ext_s   = 1'b0;
    evt_brk_s   = 1'b0;
    if (byte_valid_r) begin
      if (byte_r == 8'hE0) begin
        case (state_r)
          ST_IDLE: state_nxt_s = ST_EXT;
          ST_BRK:  state_nxt_s = ST_EXT_BRK;
          default: state_nxt_s = state_r;
        endcase
      end else if (byte_r == 8'hF0) begin
        case (state_r)
          ST_IDLE: state_nxt_s = ST_BRK;
          ST_EXT:  state_nxt_s = ST_EXT_BRK;
          default: state_nxt_s = state_r;
        endcase
      end else begin
        evt_s       = 1'b1;
        evt_ext_s   = (state_r == ST_EXT) || (state_r == ST_EXT_BRK);
        evt_brk_s   = (state_r == ST_BRK) || (state_r == ST_EXT_BRK);
        state_nxt_s = ST_IDLE;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Per-key update. Every matching key changes, and clear_keys overrides all updates and pulses.
  always_comb begin
    upd_held_s    = key_held_r;
    upd_press_s   = {NUM_KEYS{1'b0}};
    upd_release_s = {NUM_KEYS{1'b0}};
    upd_repeat_s  = {NUM_KEYS{1'b0}};
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (evt_s && (byte_r == KEY_CODES[8*i +: 8]) && (evt_ext_s == KEY_EXT[i])) begin
        if (!evt_brk_s) begin
          upd_held_s[i]   = 1'b1;
          upd_press_s[i]  = ~key_held_r[i];
          upd_repeat_s[i] = key_held_r[i];
        end else begin
          upd_held_s[i]    = 1'b0;
          upd_release_s[i] = key_held_r[i];
        end
      end else begin
        upd_held_s[i] = key_held_r[i];
      end
    end
    held_nxt_s    = clear_keys ? {NUM_KEYS{1'b0}} : upd_held_s;
    press_nxt_s   = clear_keys ? {NUM_KEYS{1'b0}} : upd_press_s;
    release_nxt_s = clear_keys ? {NUM_KEYS{1'b0}} : upd_release_s;
    repeat_nxt_s  = clear_keys ? {NUM_KEYS{1'b0}} : upd_repeat_s;
  end

  // Registered key state, event pulses and scan payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_held_r    <= {NUM_KEYS{1'b0}};
      key_press_r   <= {NUM_KEYS{1'b0}};
      key_release_r <= {NUM_KEYS{1'b0}};
      key_repeat_r  <= {NUM_KEYS{1'b0}};
      scan_valid_r  <= 1'b0;
      scan_code_r   <= 8'd0;
      scan_ext_r    <= 1'b0;
      scan_brk_r    <= 1'b0;
    end else begin
      key_held_r    <= held_nxt_s;
      key_press_r   <= press_nxt_s;
      key_release_r <= release_nxt_s;
      key_repeat_r  <= repeat_nxt_s;
      scan_valid_r  <= evt_s;
      if (evt_s) begin
        scan_code_r <= byte_r;
        scan_ext_r  <= evt_ext_s;
        scan_brk_r  <= evt_brk_s;
      end
    end
  end

  assign key_held    = key_held_r;
  assign key_press   = key_press_r;
  assign key_release = key_release_r;
  assign key_repeat  = key_repeat_r;
  assign scan_valid  = scan_valid_r;
  assign scan_code   = scan_code_r;
  assign scan_ext    = scan_ext_r;
  assign scan_brk    = scan_brk_r;
  assign parity_err  = parity_err_r;
  assign frame_err   = frame_err_r;

endmodule
